// File: rtl/scr1_clkctl.sv
// Automatic core clock-gating controller: counts idle cycles, drops the
// clock-gate enable, and runs a fixed settle window on wake before ready.
module scr1_clkctl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        test_mode,
  input  logic        sleep_en,
  input  logic        core_idle,
  input  logic        wake_req,
  input  logic        cnt_clr,
  output logic        clk_en,
  output logic        core_rdy,
  output logic        sleep_st,
  output logic [15:0] gated_cycles
);

  typedef enum logic [1:0] {RUN, IDLE_CNT, GATED, WAKE} state_e;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        clk_en_q, clk_en_d;
  logic        core_rdy_q, core_rdy_d;
  logic        sleep_st_q, sleep_st_d;
  logic [15:0] gated_q, gated_d;
  logic        abort;

  assign abort = ~core_idle | wake_req | ~sleep_en | test_mode;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!abort) begin
          state_d = IDLE_CNT;
          cnt_d   = 8'd0;
        end
      end
      IDLE_CNT: begin
        if (abort)                   state_d = RUN;
        else if (cnt_q == IDLE_LAST) state_d = GATED;
        else                         cnt_d   = cnt_q + 8'd1;
      end
      GATED: begin
        if (abort) begin
          state_d = WAKE;
          cnt_d   = 8'd0;
        end
      end
      WAKE: begin
        // Settle window is unconditional; only reset can cut it short.
        if (cnt_q == WAKE_LAST) state_d = RUN;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are flopped from next-state so they track state_q glitch-free.
  always_comb begin
    clk_en_d   = (state_d != GATED);
    sleep_st_d = (state_d == GATED);
    core_rdy_d = (state_d == RUN) || (state_d == IDLE_CNT);
    gated_d    = gated_q;
    if (cnt_clr)
      gated_d = 16'd0;
    else if (state_q == GATED && gated_q != 16'hFFFF)
      gated_d = gated_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= 8'd0;
      clk_en_q   <= 1'b1;
      core_rdy_q <= 1'b1;
      sleep_st_q <= 1'b0;
      gated_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      core_rdy_q <= core_rdy_d;
      sleep_st_q <= sleep_st_d;
      gated_q    <= gated_d;
    end
  end

  assign clk_en       = clk_en_q;
  assign core_rdy     = core_rdy_q;
  assign sleep_st     = sleep_st_q;
  assign gated_cycles = gated_q;

endmodule
